// File: rtl/prog_clk_div.sv
// Programmable clock divider with 50%-ish duty for odd divisors.
// Divisor changes take effect only at period boundaries.
module prog_clk_div #(
    parameter int WIDTH    = 8,
    parameter int DIV_INIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             pend,
    output logic             err,
    output logic [WIDTH-1:0] div_cur
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_INIT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             q_pos_q;
    logic             q_pos_d;
    logic             q_neg_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_d;
    logic             pend_q;
    logic             pend_d;
    logic [WIDTH-1:0] pval_q;
    logic [WIDTH-1:0] pval_d;
    logic             err_q;
    logic             err_d;

    logic             load_ok;
    logic             load_bad;
    logic             wrap;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;

    assign load_ok  = load && (div_in >= TWO);
    assign load_bad = load && (div_in < TWO);
    assign wrap     = (cnt_q == (div_q - ONE));
    assign half     = div_q >> 1;
    assign cnt_inc  = cnt_q + ONE;

    // Next-state, counter, phase flop and divisor bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_pos_d = q_pos_q;
        div_d   = div_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        err_d   = load_bad;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                q_pos_d = 1'b0;
                if (load_ok) begin
                    div_d = div_in;
                end
                if (en) begin
                    state_d = RUN;
                    q_pos_d = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    if (pend_q) begin
                        div_d = pval_q;
                    end
                    if (!en) begin
                        // Stopping: a coincident load is simply the
                        // latest divisor, so it lands directly.
                        state_d = IDLE;
                        q_pos_d = 1'b0;
                        if (load_ok) begin
                            div_d = div_in;
                        end
                    end else begin
                        q_pos_d = 1'b1;
                        if (load_ok) begin
                            pval_d = div_in;
                            pend_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    q_pos_d = (cnt_inc < half);
                    if (load_ok) begin
                        pval_d = div_in;
                        pend_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Rising-edge state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_pos_q <= 1'b0;
            div_q   <= DIV_RST;
            pend_q  <= 1'b0;
            pval_q  <= DIV_RST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_pos_q <= q_pos_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            err_q   <= err_d;
        end
    end

    // Half-cycle delayed copy of the phase, stretches odd divisors.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_pos_q;
        end
    end

    assign clk_out = div_q[0] ? (q_pos_q | q_neg_q) : q_pos_q;
    assign busy    = (state_q == RUN);
    assign tick    = busy && (cnt_q == '0);
    assign pend    = pend_q;
    assign err     = err_q;
    assign div_cur = div_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: period/phase model plus directed
// scenarios with hand-counted waveform expectations.
module tb_prog_clk_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       pend;
    logic       err;
    logic [7:0] div_cur;

    prog_clk_div #(.WIDTH(8), .DIV_INIT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy),
        .pend    (pend),
        .err     (err),
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: which half-cycle of which period we are in.
    // Output is high for the first N half-cycles of a 2N half-cycle period.
    bit m_valid = 0;
    bit m_rst = 0;
    bit m_run = 0;
    bit m_pend = 0;
    bit m_err = 0;
    bit m_ok;
    int m_p = 0;
    int m_n = 3;
    int m_pval = 0;

    always @(posedge clk) begin
        m_ok = load && (div_in >= 2);
        m_rst = !rst_n;
        if (!rst_n) begin
            m_valid = 1;
            m_run = 0;
            m_p = 0;
            m_n = 3;
            m_pend = 0;
            m_err = 0;
        end else begin
            m_err = load && (div_in < 2);
            if (!m_run) begin
                if (m_ok) m_n = int'(div_in);
                if (en) begin
                    m_run = 1;
                    m_p = 0;
                end
            end else if (m_p == m_n - 1) begin
                if (m_pend) m_n = m_pval;
                m_pend = 0;
                m_p = 0;
                if (!en) begin
                    m_run = 0;
                    if (m_ok) m_n = int'(div_in);
                end else if (m_ok) begin
                    m_pend = 1;
                    m_pval = int'(div_in);
                end
            end else begin
                m_p++;
                if (m_ok) begin
                    m_pend = 1;
                    m_pval = int'(div_in);
                end
            end
        end
    end

    // Compare every half cycle against the model.
    always begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("busy", int'(busy), int'(m_run));
            chk("tick", int'(tick), int'(m_run && m_p == 0));
            chk("pend", int'(pend), int'(m_pend));
            chk("div_cur", int'(div_cur), m_n);
            chk("err", int'(err), int'(m_err));
            if (!m_rst)
                chk("clk_out_h1", int'(clk_out), int'(m_run && (2 * m_p < m_n)));
        end
        @(negedge clk);
        #1;
        if (m_valid)
            chk("clk_out_h2", int'(clk_out), int'(m_run && (2 * m_p + 1 < m_n)));
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Stop in the last cycle of the current period (bounded).
    task automatic sync_end();
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (m_run && m_p == m_n - 1) break;
        end
        if (i == 600) chk("sync_timeout", 0, 1);
    endtask

    task automatic measure(input int k, output int hi, output int tk);
        hi = 0;
        tk = 0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            hi += int'(clk_out === 1'b1);
            tk += int'(tick === 1'b1);
            @(negedge clk);
            #1;
            hi += int'(clk_out === 1'b1);
        end
    endtask

    initial begin
        int hi;
        int tk;
        rst_n = 0;
        repeat (3) nxt();
        chk("rst_div_cur", int'(div_cur), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clk_out", int'(clk_out), 0);
        rst_n = 1;
        en = 1;

        // N=3 free run
        sync_end();
        measure(3, hi, tk);
        chk("n3_high_halves", hi, 3);
        chk("n3_ticks", tk, 1);
        chk("n3_busy", int'(busy), 1);
        measure(6, hi, tk);
        chk("n3x2_high_halves", hi, 6);
        chk("n3x2_ticks", tk, 2);

        // load 5 at cnt=1
        nxt();
        nxt();
        load = 1;
        div_in = 8'd5;
        nxt();
        load = 0;
        chk("n5_pend", int'(pend), 1);
        chk("n5_old_div", int'(div_cur), 3);
        measure(5, hi, tk);
        chk("n5_high_halves", hi, 5);
        chk("n5_ticks", tk, 1);
        chk("n5_div", int'(div_cur), 5);
        chk("n5_pend_clr", int'(pend), 0);

        // rejected loads
        load = 1;
        div_in = 8'd1;
        nxt();
        chk("rej1_err", int'(err), 1);
        chk("rej1_div", int'(div_cur), 5);
        chk("rej1_pend", int'(pend), 0);
        div_in = 8'd0;
        nxt();
        chk("rej0_err", int'(err), 1);
        load = 0;
        nxt();
        chk("rej_err_clr", int'(err), 0);
        chk("rej_div", int'(div_cur), 5);
        sync_end();
        measure(5, hi, tk);
        chk("rej_high_halves", hi, 5);

        // N=6, stop mid-period
        load = 1;
        div_in = 8'd6;
        nxt();
        load = 0;
        sync_end();
        measure(6, hi, tk);
        chk("n6_high_halves", hi, 6);
        chk("n6_ticks", tk, 1);
        nxt();
        nxt();
        en = 0;
        repeat (4) nxt();
        chk("stop_busy_cnt5", int'(busy), 1);
        nxt();
        chk("stop_busy", int'(busy), 0);
        chk("stop_clk_out", int'(clk_out), 0);
        chk("stop_tick", int'(tick), 0);
        repeat (3) nxt();
        chk("idle_busy", int'(busy), 0);

        // load 4 in IDLE
        load = 1;
        div_in = 8'd4;
        nxt();
        load = 0;
        chk("idle_load_div", int'(div_cur), 4);
        chk("idle_load_pend", int'(pend), 0);
        en = 1;
        sync_end();
        measure(8, hi, tk);
        chk("n4_high_halves", hi, 8);
        chk("n4_ticks", tk, 2);

        // load coincident with wrap while one is pending
        nxt();
        load = 1;
        div_in = 8'd5;
        nxt();
        load = 0;
        chk("coin_pend1", int'(pend), 1);
        chk("coin_div4", int'(div_cur), 4);
        sync_end();
        load = 1;
        div_in = 8'd6;
        nxt();
        load = 0;
        chk("coin_div5", int'(div_cur), 5);
        chk("coin_pend2", int'(pend), 1);
        sync_end();
        measure(6, hi, tk);
        chk("coin_n6_high", hi, 6);
        chk("coin_div6", int'(div_cur), 6);
        chk("coin_pend_clr", int'(pend), 0);

        // N=7, overwrite pending, then reset
        load = 1;
        div_in = 8'd7;
        nxt();
        load = 0;
        sync_end();
        nxt();
        chk("n7_div", int'(div_cur), 7);
        load = 1;
        div_in = 8'd8;
        nxt();
        div_in = 8'd9;
        nxt();
        load = 0;
        chk("n7_pend", int'(pend), 1);
        chk("n7_div_hold", int'(div_cur), 7);
        rst_n = 0;
        nxt();
        chk("mrst_div", int'(div_cur), 3);
        chk("mrst_pend", int'(pend), 0);
        chk("mrst_clk_out", int'(clk_out), 0);
        chk("mrst_busy", int'(busy), 0);
        rst_n = 1;
        sync_end();
        measure(3, hi, tk);
        chk("restart_high", hi, 3);
        chk("restart_ticks", tk, 1);

        // boundaries: max and min divisor
        load = 1;
        div_in = 8'd255;
        nxt();
        load = 0;
        sync_end();
        measure(255, hi, tk);
        chk("n255_high", hi, 255);
        chk("n255_ticks", tk, 1);
        nxt();
        load = 1;
        div_in = 8'd2;
        nxt();
        load = 0;
        sync_end();
        measure(4, hi, tk);
        chk("n2_high", hi, 4);
        chk("n2_ticks", tk, 2);
        chk("n2_div", int'(div_cur), 2);

        en = 0;
        repeat (4) nxt();
        chk("end_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the divisor width in bits.
REQ-002 SHALL have parameter DIV_INIT, default 3, giving the divisor after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; rising and falling edges are both used.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on clk edges.
REQ-005 SHALL have port en  input  1  run request; high runs the divider, low stops it at a period boundary.
REQ-006 SHALL have port load  input  1  one-cycle strobe requesting a new divisor.
REQ-007 SHALL have port div_in  input  WIDTH  requested divisor, qualified by load.
REQ-008 SHALL have port clk_out  output  1  divided clock.
REQ-009 SHALL have port tick  output  1  one-clk pulse marking the start of each output period.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port pend  output  1  an accepted divisor is waiting for a period boundary.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a load is rejected.
REQ-013 SHALL have port div_cur  output  WIDTH  divisor currently in effect.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN, a posedge counter cnt (0..div_cur-1), a posedge flop q_pos and a negedge flop q_neg.
REQ-015 SHALL, in IDLE, hold cnt=0, q_pos=0 and clk_out=0.
REQ-016 SHALL move from IDLE to RUN on the edge where en=1; at that edge cnt=0 and q_pos=1.
REQ-017 SHALL, in RUN, advance cnt by 1 per posedge and wrap from div_cur-1 to 0.
REQ-018 SHALL, in RUN, register q_pos = (next cnt < div_cur>>1).
REQ-019 SHALL make q_neg copy q_pos on every negedge.
REQ-020 SHALL drive clk_out = q_pos when div_cur is even, and q_pos OR q_neg when div_cur is odd.
REQ-021 Resulting duty: even N gives N/2 cycles high; odd N gives N/2 cycles high (e.g. 1.5 of 3); period is N clk cycles.
REQ-022 SHALL drive clk_out from flops only, with no glitches, including across divisor changes.
REQ-023 SHALL assert tick for one clk cycle whenever busy=1 and cnt=0.
REQ-024 SHALL, when en=0 at an edge in RUN where cnt=div_cur-1, go to IDLE; the current period always completes.
REQ-025 SHALL reject a load with div_in<2: err pulses for 1 cycle, and div_cur and pend are unchanged.
REQ-026 SHALL, on an accepted load in IDLE, set div_cur=div_in at the next edge and leave pend=0.
REQ-027 SHALL, on an accepted load in RUN, store div_in as pending and set pend=1.
REQ-028 SHALL, at the wrap edge (cnt=div_cur-1), copy the pending value to div_cur and clear pend.
REQ-029 SHALL let a new load while pend=1 overwrite the pending value (last write wins).
REQ-030 SHALL treat a load coincident with a wrap edge as follows: the previously pending value (if any) is applied at that edge; the new value becomes pending for the next boundary.
REQ-031 SHALL, when en=0 and a value is pending at the final wrap, apply that value on entry to IDLE.
REQ-032 SHALL use WIDTH-bit arithmetic only; div_cur>>1 is the floor half, with no overflow at div_cur=2^WIDTH-1.

Reset
REQ-033 SHALL, while rst_n=0 at a posedge: state=IDLE, cnt=0, q_pos=0, div_cur=DIV_INIT, pend=0, err=0, tick=0.
REQ-034 SHALL clear q_neg to 0 while rst_n=0 at a negedge.
REQ-035 SHALL let reset mid-RUN override en and load, forcing clk_out=0 within half a clk cycle.
REQ-036 SHALL discard any pending divisor on reset.

Verification
REQ-037 Reset, en=1, DIV_INIT=3 -> clk_out period 3 clk cycles, high 1.5 cycles, tick every 3rd cycle, busy=1.
REQ-038 In IDLE, load div_in=4, then en=1 -> div_cur=4, clk_out 2 cycles high / 2 cycles low, pend never set.
REQ-039 Running N=3, load div_in=5 at cnt=1 -> pend=1 until the wrap; the next period is 5 cycles with 2.5 cycles high; no runt pulse.
REQ-040 load div_in=1, then div_in=0 -> err pulses twice, div_cur and the waveform are unchanged.
REQ-041 Running N=6, en drops at cnt=2 -> the period completes (cnt reaches 5), then IDLE, clk_out=0, busy=0, tick stops.
REQ-042 Running N=7 with a pending value 9, rst_n=0 for 1 cycle -> div_cur=3, pend=0, clk_out low; restart with N=3.
